// File: rtl/uv_edge_buffer_pkg.sv
// Shared constants and FSM encoding for the chroma intra-prediction edge buffer.
package uv_edge_buffer_pkg;

    localparam logic [7:0]  UV_TOP_INIT  = 8'd127;
    localparam logic [7:0]  UV_LEFT_INIT = 8'd129;
    localparam int unsigned UV_N         = 8;
    localparam int unsigned UV_PLANE_W   = 8 * UV_N;
    localparam int unsigned UV_ROW_W     = 2 * UV_PLANE_W;
    localparam int unsigned UV_BLK_W     = UV_PLANE_W * UV_N;

    typedef enum logic [5:0] {
        ST_IDLE  = 6'b000001,
        ST_F_RD  = 6'b000010,
        ST_F_OUT = 6'b000100,
        ST_S_RD  = 6'b001000,
        ST_S_WR  = 6'b010000,
        ST_DONE  = 6'b100000
    } uv_state_e;

    function automatic logic [UV_PLANE_W-1:0] uv_fill(input logic [7:0] b);
        return {UV_N{b}};
    endfunction

endpackage

// File: rtl/uv_top_ram.sv
// Simple dual-port top-row store: one write port, one registered read port; read-during-write returns old data.
module uv_top_ram #(
    parameter int unsigned W     = 128,
    parameter int unsigned DEPTH = 1024,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uv_edge_buffer.sv
// Chroma border buffer: keeps the row above (per MB column), the left column and the corner
// sample of reconstructed U/V, and presents them as intra-prediction neighbours for the next MB.
module uv_edge_buffer
    import uv_edge_buffer_pkg::*;
#(
    parameter int unsigned BLOCK_SIZE = 8,
    parameter int unsigned MB_COLS    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        fetch_start,
    input  logic                        store_start,
    input  logic [9:0]                  x,
    input  logic [9:0]                  y,
    input  logic [8*16*BLOCK_SIZE-1:0]  recon,
    output logic                        busy,
    output logic [63:0]                 top_u,
    output logic [63:0]                 top_v,
    output logic [63:0]                 left_u,
    output logic [63:0]                 left_v,
    output logic [7:0]                  top_left_u,
    output logic [7:0]                  top_left_v,
    output logic                        fetch_done,
    output logic                        store_done
);

    localparam int unsigned AW      = $clog2(MB_COLS);
    localparam int unsigned ROW7_LO = UV_PLANE_W * (UV_N - 1);

    uv_state_e state_q, state_d;
    logic [9:0]            x_q, x_d;
    logic                  y_zero_q, y_zero_d;
    logic                  busy_q, busy_d;
    logic                  fetch_done_q, fetch_done_d;
    logic                  store_done_q, store_done_d;
    logic [UV_PLANE_W-1:0] top_u_q, top_u_d, top_v_q, top_v_d;
    logic [UV_PLANE_W-1:0] left_u_q, left_u_d, left_v_q, left_v_d;
    logic [7:0]            tl_u_q, tl_u_d, tl_v_q, tl_v_d;
    logic [UV_PLANE_W-1:0] lreg_u_q, lreg_u_d, lreg_v_q, lreg_v_d;
    logic [7:0]            corner_u_q, corner_u_d, corner_v_q, corner_v_d;

    logic                  rd_en_c;
    logic [AW-1:0]         rd_addr_c;
    logic                  wr_en_c;
    logic [UV_ROW_W-1:0]   wr_data_c;
    logic [UV_ROW_W-1:0]   rd_data_c;
    logic                  unused_recon_c;

    uv_top_ram #(
        .W     (UV_ROW_W),
        .DEPTH (MB_COLS)
    ) u_top_ram (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en_c),
        .wr_addr_i (AW'(x_q)),
        .wr_data_i (wr_data_c),
        .rd_en_i   (rd_en_c),
        .rd_addr_i (rd_addr_c),
        .rd_data_o (rd_data_c)
    );

    // Only row 7 and column 7 of each plane are ever kept.
    assign unused_recon_c = ^recon;
    assign wr_data_c      = {recon[UV_BLK_W + ROW7_LO +: UV_PLANE_W], recon[ROW7_LO +: UV_PLANE_W]};

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_zero_d     = y_zero_q;
        fetch_done_d = 1'b0;
        store_done_d = 1'b0;
        top_u_d      = top_u_q;
        top_v_d      = top_v_q;
        left_u_d     = left_u_q;
        left_v_d     = left_v_q;
        tl_u_d       = tl_u_q;
        tl_v_d       = tl_v_q;
        lreg_u_d     = lreg_u_q;
        lreg_v_d     = lreg_v_q;
        corner_u_d   = corner_u_q;
        corner_v_d   = corner_v_q;
        rd_en_c      = 1'b0;
        rd_addr_c    = AW'(x_q);
        wr_en_c      = 1'b0;

        case (state_q)
            // The RAM read is launched on accept so the word is ready while in F_RD/S_RD.
            ST_IDLE: begin
                if (store_start || fetch_start) begin
                    state_d   = store_start ? ST_S_RD : ST_F_RD;
                    x_d       = x;
                    y_zero_d  = (y == 10'd0);
                    rd_en_c   = 1'b1;
                    rd_addr_c = AW'(x);
                end
            end
            ST_F_RD: begin
                state_d      = ST_F_OUT;
                fetch_done_d = 1'b1;
                if (y_zero_q) begin
                    top_u_d = uv_fill(UV_TOP_INIT);
                    top_v_d = uv_fill(UV_TOP_INIT);
                    tl_u_d  = UV_TOP_INIT;
                    tl_v_d  = UV_TOP_INIT;
                end else begin
                    top_u_d = rd_data_c[0 +: UV_PLANE_W];
                    top_v_d = rd_data_c[UV_PLANE_W +: UV_PLANE_W];
                    tl_u_d  = (x_q == 10'd0) ? UV_LEFT_INIT : corner_u_q;
                    tl_v_d  = (x_q == 10'd0) ? UV_LEFT_INIT : corner_v_q;
                end
                left_u_d = (x_q == 10'd0) ? uv_fill(UV_LEFT_INIT) : lreg_u_q;
                left_v_d = (x_q == 10'd0) ? uv_fill(UV_LEFT_INIT) : lreg_v_q;
            end
            ST_F_OUT: begin
                state_d = ST_IDLE;
            end
            // Old RAM word still holds row y-1; its last byte is the corner for (x+1,y).
            ST_S_RD: begin
                state_d      = ST_S_WR;
                store_done_d = 1'b1;
                wr_en_c      = 1'b1;
                corner_u_d   = y_zero_q ? 8'd0 : rd_data_c[UV_PLANE_W-8 +: 8];
                corner_v_d   = y_zero_q ? 8'd0 : rd_data_c[UV_ROW_W-8 +: 8];
                for (int r = 0; r < int'(UV_N); r++) begin
                    lreg_u_d[8*r +: 8] = recon[UV_PLANE_W*r + 8*(UV_N-1) +: 8];
                    lreg_v_d[8*r +: 8] = recon[UV_BLK_W + UV_PLANE_W*r + 8*(UV_N-1) +: 8];
                end
            end
            ST_S_WR: begin
                state_d = ST_IDLE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            x_q          <= '0;
            y_zero_q     <= 1'b0;
            busy_q       <= 1'b0;
            fetch_done_q <= 1'b0;
            store_done_q <= 1'b0;
            top_u_q      <= '0;
            top_v_q      <= '0;
            left_u_q     <= '0;
            left_v_q     <= '0;
            tl_u_q       <= '0;
            tl_v_q       <= '0;
            lreg_u_q     <= '0;
            lreg_v_q     <= '0;
            corner_u_q   <= '0;
            corner_v_q   <= '0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_zero_q     <= y_zero_d;
            busy_q       <= busy_d;
            fetch_done_q <= fetch_done_d;
            store_done_q <= store_done_d;
            top_u_q      <= top_u_d;
            top_v_q      <= top_v_d;
            left_u_q     <= left_u_d;
            left_v_q     <= left_v_d;
            tl_u_q       <= tl_u_d;
            tl_v_q       <= tl_v_d;
            lreg_u_q     <= lreg_u_d;
            lreg_v_q     <= lreg_v_d;
            corner_u_q   <= corner_u_d;
            corner_v_q   <= corner_v_d;
        end
    end

    assign busy       = busy_q;
    assign fetch_done = fetch_done_q;
    assign store_done = store_done_q;
    assign top_u      = top_u_q;
    assign top_v      = top_v_q;
    assign left_u     = left_u_q;
    assign left_v     = left_v_q;
    assign top_left_u = tl_u_q;
    assign top_left_v = tl_v_q;

endmodule
